// File: rtl/register_file_param.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// optional write-to-read bypass, hardwired zero entry, and a post-reset clear sweep.
module register_file_param #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter bit                ZERO_REG = 1'b1,
  parameter bit                BYPASS   = 1'b1,
  parameter int unsigned       SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = '0,
  parameter int unsigned       V0_IDX   = 2,
  parameter int unsigned       V1_IDX   = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              ClearReq,
  output logic              Busy,
  output logic [DATA_W-1:0] v0,
  output logic [DATA_W-1:0] v1
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   SP_CNT   = (ADDR_W+1)'(SP_IDX);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] V0_ADDR  = ADDR_W'(V0_IDX);
  localparam logic [ADDR_W-1:0] V1_ADDR  = ADDR_W'(V1_IDX);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // A user write is live only in READY; the zero entry swallows writes when hardwired.
  assign user_we = (state_q == READY) && RegWrite &&
                   !(ZERO_REG && (WriteRegister == {ADDR_W{1'b0}}));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = WriteRegister;
    mem_wdata = WriteData;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q[ADDR_W-1:0];
        mem_wdata = (cnt_q == SP_CNT) ? SP_INIT : {DATA_W{1'b0}};
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d = READY;
        end else begin
          state_d = CLEAR;
        end
      end
      READY: begin
        mem_we = user_we;
        if (ClearReq) begin
          state_d = CLEAR;
          cnt_d   = {(ADDR_W+1){1'b0}};
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= CLEAR;
      cnt_q   <= {(ADDR_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array needs no reset: every entry is rewritten by the sweep before reads are unmasked.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] stored);
    logic [DATA_W-1:0] r;
    if (state_q != READY) begin
      r = {DATA_W{1'b0}};
    end else if (ZERO_REG && (addr == {ADDR_W{1'b0}})) begin
      r = {DATA_W{1'b0}};
    end else if (BYPASS && user_we && (WriteRegister == addr)) begin
      r = WriteData;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  assign ReadData1 = read_sel(ReadRegister1, mem_q[ReadRegister1]);
  assign ReadData2 = read_sel(ReadRegister2, mem_q[ReadRegister2]);
  assign v0        = read_sel(V0_ADDR, mem_q[V0_ADDR]);
  assign v1        = read_sel(V1_ADDR, mem_q[V1_ADDR]);
  assign Busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: instance A (32x32, bypass) and instance B (8x16, no bypass) share clock and reset.
module tb_register_file_param;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;

  logic [4:0]  rr1_a = '0, rr2_a = '0, wa_a = '0;
  logic [31:0] wd_a = '0, rd1_a, rd2_a, v0_a, v1_a;
  logic        we_a = 1'b0, clr_a = 1'b0, busy_a;

  logic [2:0]  rr1_b = '0, rr2_b = '0, wa_b = '0;
  logic [15:0] wd_b = '0, rd1_b, rd2_b, v0_b, v1_b;
  logic        we_b = 1'b0, clr_b = 1'b0, busy_b;

  always #5 Clk = ~Clk;

  register_file_param #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1),
    .SP_IDX(29), .SP_INIT(32'h0000_1FFC), .V0_IDX(2), .V1_IDX(3)
  ) dut_a (
    .Clk(Clk), .Rst(Rst),
    .ReadRegister1(rr1_a), .ReadRegister2(rr2_a),
    .ReadData1(rd1_a), .ReadData2(rd2_a),
    .WriteRegister(wa_a), .WriteData(wd_a), .RegWrite(we_a),
    .ClearReq(clr_a), .Busy(busy_a), .v0(v0_a), .v1(v1_a)
  );

  register_file_param #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0),
    .SP_IDX(6), .SP_INIT(16'h00F0), .V0_IDX(2), .V1_IDX(3)
  ) dut_b (
    .Clk(Clk), .Rst(Rst),
    .ReadRegister1(rr1_b), .ReadRegister2(rr2_b),
    .ReadData1(rd1_b), .ReadData2(rd2_b),
    .WriteRegister(wa_b), .WriteData(wd_b), .RegWrite(we_b),
    .ClearReq(clr_b), .Busy(busy_b), .v0(v0_b), .v1(v1_b)
  );

  typedef struct {
    int          id;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;
  string       names[9] = '{"rd1_a", "rd2_a", "v0_a", "v1_a", "busy_a",
                            "rd1_b", "rd2_b", "busy_b", "v0_b"};

  function automatic logic [31:0] observe(input int id);
    case (id)
      0:       return rd1_a;
      1:       return rd2_a;
      2:       return v0_a;
      3:       return v1_a;
      4:       return {31'd0, busy_a};
      5:       return {16'd0, rd1_b};
      6:       return {16'd0, rd2_b};
      7:       return {31'd0, busy_b};
      8:       return {16'd0, v0_b};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_v(input int id, input logic [31:0] v);
    sb_q.push_back('{id, v});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: drain every pending expectation at the falling edge, away from the update edge.
  always @(negedge Clk) begin
    while (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = observe(mon_e.id);
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", names[mon_e.id], mon_act, mon_e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] model_b [8];

  initial begin
    // Reset held: both sequencers busy, outputs masked
    tick();
    expect_v(4, 32'd1);
    expect_v(7, 32'd1);
    tick();
    Rst   = 1'b0;
    rr1_a = 5'd7;
    we_a  = 1'b1;
    wa_a  = 5'd7;
    wd_a  = 32'hAAAA_5555;
    // Sweep: A busy for 32 edges, B for 8; writes during the sweep are dropped
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i >= 31) we_a = 1'b0;
      expect_v(4, (i < 32) ? 32'd1 : 32'd0);
      if (i < 32) expect_v(0, 32'd0);
      if (i <= 8) expect_v(7, (i < 8) ? 32'd1 : 32'd0);
    end

    // Post-clear contents: only the stack-pointer entry is non-zero
    for (int i = 0; i < 32; i++) begin
      rr1_a = 5'(i);
      rr2_a = 5'(31 - i);
      expect_v(0, (i == 29) ? 32'h0000_1FFC : 32'd0);
      expect_v(1, ((31 - i) == 29) ? 32'h0000_1FFC : 32'd0);
      tick();
    end

    // Bypass: same-cycle write visible on both ports, then from the array
    rr1_a = 5'd5; rr2_a = 5'd5;
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF;
    expect_v(0, 32'hDEAD_BEEF);
    expect_v(1, 32'hDEAD_BEEF);
    tick();
    we_a = 1'b0;
    expect_v(0, 32'hDEAD_BEEF);
    expect_v(1, 32'hDEAD_BEEF);
    tick();

    // v0/v1 follow entries 2 and 3 with bypass
    we_a = 1'b1; wa_a = 5'd2; wd_a = 32'h1111_2222;
    expect_v(2, 32'h1111_2222);
    expect_v(3, 32'd0);
    tick();
    wa_a = 5'd3; wd_a = 32'h3333_4444;
    expect_v(2, 32'h1111_2222);
    expect_v(3, 32'h3333_4444);
    tick();

    // Writes to the zero entry are discarded, including on the bypass path
    wa_a = 5'd0; wd_a = 32'h1234_5678; rr1_a = 5'd0;
    expect_v(0, 32'd0);
    expect_v(2, 32'h1111_2222);
    expect_v(3, 32'h3333_4444);
    tick();
    we_a = 1'b0;
    expect_v(0, 32'd0);
    tick();

    // ClearReq with a coincident write: write is forwarded, then wiped by the sweep
    we_a = 1'b1; wa_a = 5'd2; wd_a = 32'h0000_0055; clr_a = 1'b1;
    expect_v(4, 32'd0);
    expect_v(2, 32'h0000_0055);
    tick();
    we_a = 1'b0; clr_a = 1'b0;
    expect_v(4, 32'd1);
    expect_v(2, 32'd0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      expect_v(4, (i < 32) ? 32'd1 : 32'd0);
      if (i < 32) expect_v(2, 32'd0);
    end
    rr1_a = 5'd2; rr2_a = 5'd29;
    expect_v(0, 32'd0);
    expect_v(1, 32'h0000_1FFC);
    expect_v(3, 32'd0);
    expect_v(2, 32'd0);
    tick();

    // Instance B: no bypass, write/read mix against a reference array
    for (int i = 0; i < 8; i++) model_b[i] = (i == 6) ? 16'h00F0 : 16'h0000;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) begin
        we_b = 1'b1; wa_b = 3'd5; wd_b = 16'hBEEF; rr1_b = 3'd5; rr2_b = 3'd5;
      end else if (k == 1) begin
        we_b = 1'b0; rr1_b = 3'd5; rr2_b = 3'd5;
      end else if (k == 2) begin
        we_b = 1'b1; wa_b = 3'd0; wd_b = 16'h5678; rr1_b = 3'd0; rr2_b = 3'd6;
      end else begin
        we_b  = 1'($urandom_range(0, 1));
        wa_b  = 3'($urandom_range(0, 7));
        wd_b  = 16'($urandom);
        rr1_b = 3'($urandom_range(0, 7));
        rr2_b = 3'($urandom_range(0, 7));
      end
      expect_v(5, (rr1_b == 3'd0) ? 32'd0 : {16'd0, model_b[rr1_b]});
      expect_v(6, (rr2_b == 3'd0) ? 32'd0 : {16'd0, model_b[rr2_b]});
      expect_v(8, {16'd0, model_b[2]});
      if (we_b && (wa_b != 3'd0)) model_b[wa_b] = wd_b;
      tick();
    end
    we_b = 1'b0;

    // Reset mid-sweep at count 17 restarts the sweep; writes during it leave no trace
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 1; i <= 17; i++) tick();
    expect_v(4, 32'd1);
    Rst = 1'b1;
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h0000_AAAA;
    tick();
    expect_v(4, 32'd1);
    wa_a = 5'd29; wd_a = 32'h0000_BBBB;
    tick();
    Rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      we_a = (i < 31) && ((i % 2) == 1);
      expect_v(4, (i < 32) ? 32'd1 : 32'd0);
    end
    we_a = 1'b0;
    rr1_a = 5'd7; rr2_a = 5'd29; rr1_b = 3'd6; rr2_b = 3'd5;
    expect_v(0, 32'd0);
    expect_v(1, 32'h0000_1FFC);
    expect_v(5, 32'h0000_00F0);
    expect_v(6, 32'd0);
    expect_v(7, 32'd0);
    tick();

    checks++;
    if (rd1_a !== 32'd0) begin
      errors++;
      $display("FAIL final rd1_a: got %h expected %h", rd1_a, 32'd0);
    end
    checks++;
    if (rd2_a !== 32'h0000_1FFC) begin
      errors++;
      $display("FAIL final rd2_a: got %h expected %h", rd2_a, 32'h0000_1FFC);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL final busy_a: got %b expected 0", busy_a);
    end
    checks++;
    if (rd1_b !== 16'h00F0) begin
      errors++;
      $display("FAIL final rd1_b: got %h expected %h", rd1_b, 16'h00F0);
    end

    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
